// File: rtl/delay_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// delay_load_sequencer_pkg
// Shared definitions for the delay-load sequencer:
//   - address map of the per-lane delay elements (output and input delays)
//   - sequencer state encoding
//   - idx_width(): width of a {lane, address} table index
//   - addr_valid(): true for the addresses that map to a real delay element
// -----------------------------------------------------------------------------
package delay_load_sequencer_pkg;

    // Output delays: DQ0-7, DQS, DM
    localparam int ODLY_BASE = 0;
    localparam int ODLY_CNT  = 10;
    // Input delays: DQ0-7, DQS
    localparam int IDLY_BASE = 16;
    localparam int IDLY_CNT  = 9;

    // Delay address field width inside a lane
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_GAP  = 3'd2,
        ST_SET  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // Width of a {lane, address} index for the given number of lanes.
    function automatic int idx_width(input int num_lanes);
        return $clog2(num_lanes) + ADDR_W;
    endfunction

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        int a;
        a = int'(addr);
        return ((a >= ODLY_BASE) && (a < ODLY_BASE + ODLY_CNT)) ||
               ((a >= IDLY_BASE) && (a < IDLY_BASE + IDLY_CNT));
    endfunction

endpackage

// File: rtl/delay_load_sequencer_ram.sv
// -----------------------------------------------------------------------------
// dly_table_ram
// Delay value table: one synchronous write port, one combinational read port,
// intended to map onto distributed RAM.
// Ports:
//   clk_div  - clock (rising edge)
//   we       - write enable
//   waddr    - write index
//   wdata    - write data
//   raddr    - read index
//   rdata    - read data (combinational from raddr)
// -----------------------------------------------------------------------------
module dly_table_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clk_div,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; a reset port would stop it
    // mapping onto RAM primitives. Validity is tracked outside (dirty bits).
    always_ff @(posedge clk_div) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/delay_load_sequencer.sv
// -----------------------------------------------------------------------------
// delay_load_sequencer
// Holds a host-written table of per-lane delay values and, on request, walks
// the whole table, loading dirty (or, for apply_all, all valid) entries into
// the lane delay elements, then broadcasts a set strobe.
// Ports:
//   clk_div    - sole clock, rising edge
//   rst        - synchronous active-high reset
//   wr_en      - host write strobe into the table
//   wr_addr    - {lane, 5-bit delay address}
//   wr_data    - delay value (3 LSBs are the fine delay)
//   apply      - request: load dirty entries
//   apply_all  - request: load all valid entries (wins over apply)
//   dly_data   - delay value shared by all lanes (held between loads)
//   dly_addr   - delay address shared by all lanes (held between loads)
//   ld_delay   - one-hot per-lane load strobe
//   set        - broadcast strobe applying all loaded delays
//   busy       - pass in progress (until after set)
//   done       - one-cycle pulse in the cycle after set
// -----------------------------------------------------------------------------
module delay_load_sequencer
    import delay_load_sequencer_pkg::*;
#(
    parameter  int NUM_LANES = 2,
    parameter  int SET_GAP   = 2,
    localparam int IW        = idx_width(NUM_LANES)
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 apply,
    input  logic                 apply_all,
    output logic [7:0]           dly_data,
    output logic [4:0]           dly_addr,
    output logic [NUM_LANES-1:0] ld_delay,
    output logic                 set,
    output logic                 busy,
    output logic                 done
);

    localparam int NUM_IDX  = NUM_LANES * 32;
    localparam int LAST_IDX = NUM_IDX - 1;

    seq_state_t           state;
    seq_state_t           state_next;
    logic [IW-1:0]        scan_idx;
    logic [2:0]           gap_cnt;
    logic                 all_mode;
    logic                 pend;
    logic                 pend_all;
    logic [NUM_IDX-1:0]   dirty;
    logic [7:0]           rd_data;

    int                   wr_lane;
    int                   scan_lane;
    logic                 wr_hit;
    logic                 emit;
    logic                 req;
    logic [NUM_LANES-1:0] ld_next;

    dly_table_ram #(
        .DEPTH (NUM_IDX),
        .AW    (IW),
        .DW    (8)
    ) u_table (
        .clk_div (clk_div),
        .we      (wr_hit),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (scan_idx),
        .rdata   (rd_data)
    );

    // Write qualification and scan emission decode. The table read is
    // combinational, so a write landing on the index being scanned is seen
    // as old data here and takes effect only after the edge.
    always_comb begin
        wr_lane   = int'(wr_addr >> ADDR_W);
        scan_lane = int'(scan_idx >> ADDR_W);
        wr_hit    = wr_en && addr_valid(wr_addr[ADDR_W-1:0]) && (wr_lane < NUM_LANES);
        emit      = (state == ST_SCAN) && addr_valid(scan_idx[ADDR_W-1:0]) &&
                    (dirty[scan_idx] || all_mode);
        req       = apply || apply_all;
        for (int l = 0; l < NUM_LANES; l++) begin
            ld_next[l] = emit && (scan_lane == l);
        end
    end

    // Next state and state-decoded strobes.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        set        = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (scan_idx == IW'(LAST_IDX)) state_next = ST_GAP;
            end
            ST_GAP: begin
                busy = 1'b1;
                if (gap_cnt == 3'(SET_GAP - 1)) state_next = ST_SET;
            end
            ST_SET: begin
                busy       = 1'b1;
                set        = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                // A request held over from the pass (or arriving now) starts
                // the next pass straight away.
                state_next = (pend || req) ? ST_SCAN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout so every register samples the
    // pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state    <= ST_IDLE;
            scan_idx <= '0;
            gap_cnt  <= '0;
            all_mode <= 1'b0;
            pend     <= 1'b0;
            pend_all <= 1'b0;
            dirty    <= '0;
            ld_delay <= '0;
            dly_addr <= '0;
            dly_data <= '0;
        end else begin
            state    <= state_next;
            ld_delay <= ld_next;

            if (emit) begin
                dly_addr        <= scan_idx[ADDR_W-1:0];
                dly_data        <= rd_data;
                dirty[scan_idx] <= 1'b0;
            end
            // Placed after the clear: a same-cycle write keeps the bit set.
            if (wr_hit) begin
                dirty[wr_addr] <= 1'b1;
            end

            if ((state == ST_SCAN) && (state_next == ST_SCAN)) begin
                scan_idx <= scan_idx + 1'b1;
            end else begin
                scan_idx <= '0;
            end

            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 3'd1;
            end else begin
                gap_cnt <= '0;
            end

            if ((state_next == ST_SCAN) && (state != ST_SCAN)) begin
                // Pass start: fold held and fresh requests into the pass mode.
                all_mode <= apply_all || pend_all;
                pend     <= 1'b0;
                pend_all <= 1'b0;
            end else if ((state != ST_IDLE) && req) begin
                pend <= 1'b1;
                if (apply_all) pend_all <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_delay_load_sequencer
// Directed scenarios plus a randomized stretch. Every cycle the DUT outputs are
// compared with a reference model that tracks the table contents, dirty set
// and the pass timeline as a cycle offset from the accepted request.
// -----------------------------------------------------------------------------
module tb_delay_load_sequencer;

    localparam int NL       = 2;
    localparam int SG       = 2;
    localparam int NI       = NL * 32;
    localparam int IW       = 6;
    localparam int PASS_LAT = NI + SG + 2;   // apply cycle to done cycle

    logic          clk_div   = 1'b0;
    logic          rst       = 1'b1;
    logic          wr_en     = 1'b0;
    logic [IW-1:0] wr_addr   = '0;
    logic [7:0]    wr_data   = '0;
    logic          apply     = 1'b0;
    logic          apply_all = 1'b0;
    logic [7:0]    dly_data;
    logic [4:0]    dly_addr;
    logic [NL-1:0] ld_delay;
    logic          set;
    logic          busy;
    logic          done;

    always #5 clk_div = ~clk_div;

    delay_load_sequencer #(
        .NUM_LANES (NL),
        .SET_GAP   (SG)
    ) dut (
        .clk_div   (clk_div),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .apply     (apply),
        .apply_all (apply_all),
        .dly_data  (dly_data),
        .dly_addr  (dly_addr),
        .ld_delay  (ld_delay),
        .set       (set),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;   // index of the current clock interval

    // Reference model state
    logic [7:0]    m_data  [NI];
    bit            m_dirty [NI];
    bit            m_active   = 1'b0;
    bit            m_all      = 1'b0;
    bit            m_pend     = 1'b0;
    bit            m_pend_all = 1'b0;
    int            m_start    = 0;     // interval in which index 0 is scanned
    logic [NL-1:0] e_ld   = '0;
    logic [4:0]    e_addr = '0;
    logic [7:0]    e_data = '0;
    bit            e_set  = 1'b0;
    bit            e_busy = 1'b0;
    bit            e_done = 1'b0;

    // Observed loads
    int            log_idx  [$];
    logic [7:0]    log_data [$];
    logic [NL-1:0] log_ld   [$];
    int            set_cnt  = 0;
    int            done_cnt = 0;
    int            set_cyc  = 0;
    int            done_cyc = 0;

    function automatic bit tb_valid(input int a);
        return (a <= 9) || ((a >= 16) && (a <= 24));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_step();
        int ph;
        int k;
        int wa;
        if (rst) begin
            foreach (m_dirty[i]) m_dirty[i] = 1'b0;
            m_active = 1'b0; m_pend = 1'b0; m_pend_all = 1'b0; m_all = 1'b0;
            e_ld = '0; e_addr = '0; e_data = '0;
            e_set = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            return;
        end
        ph   = m_active ? (cyc - m_start) : -1;
        e_ld = '0;
        if (m_active && (ph >= 0) && (ph < NI)) begin
            k = ph;
            if (tb_valid(k % 32) && (m_dirty[k] || m_all)) begin
                e_ld       = NL'(1) << (k / 32);
                e_addr     = 5'(k % 32);
                e_data     = m_data[k];
                m_dirty[k] = 1'b0;
            end
        end
        wa = int'(wr_addr);
        if (wr_en && tb_valid(wa % 32) && ((wa / 32) < NL)) begin
            m_data[wa]  = wr_data;
            m_dirty[wa] = 1'b1;
        end
        if (!m_active) begin
            if (apply || apply_all) begin
                m_active = 1'b1; m_start = cyc + 1; m_all = apply_all;
            end
        end else if (ph == NI + SG + 1) begin
            if (m_pend || apply || apply_all) begin
                m_start = cyc + 1; m_all = m_pend_all || apply_all;
                m_pend = 1'b0; m_pend_all = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end else if (apply || apply_all) begin
            m_pend = 1'b1;
            if (apply_all) m_pend_all = 1'b1;
        end
        ph     = cyc + 1 - m_start;
        e_busy = m_active && (ph >= 0) && (ph <= NI + SG);
        e_set  = m_active && (ph == NI + SG);
        e_done = m_active && (ph == NI + SG + 1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_div);
        #1;
        cyc++;
        check("ld_delay", 32'(ld_delay), 32'(e_ld));
        check("dly_addr", 32'(dly_addr), 32'(e_addr));
        check("dly_data", 32'(dly_data), 32'(e_data));
        check("set",      32'(set),      32'(e_set));
        check("busy",     32'(busy),     32'(e_busy));
        check("done",     32'(done),     32'(e_done));
        if (ld_delay != '0) begin
            for (int l = 0; l < NL; l++) begin
                if (ld_delay[l]) log_idx.push_back(l * 32 + int'(dly_addr));
            end
            log_data.push_back(dly_data);
            log_ld.push_back(ld_delay);
        end
        if (set)  begin set_cnt++;  set_cyc  = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        wr_en = 1'b0; apply = 1'b0; apply_all = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin rst = 1'b1; tick(); end
    endtask

    task automatic write(input int lane, input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = IW'(lane * 32 + addr);
        wr_data = 8'(data);
        tick();
    endtask

    task automatic clear_log();
        log_idx.delete(); log_data.delete(); log_ld.delete();
        set_cnt = 0; done_cnt = 0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        bit got;
        n = 0; got = 1'b0;
        while ((n < budget) && !got) begin
            tick();
            n++;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int apply_cyc;
        int d1;
        int exp_q [$];

        // Reset state
        do_reset(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ld",   32'(ld_delay), 32'd0);

        // Single dirty entry, lane 1 addr 3
        write(1, 3, 8'h5A);
        clear_log();
        apply = 1'b1; apply_cyc = cyc;
        run_until_done("t35", 200);
        check("t35_pulses", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() > 0) begin
            check("t35_ld",   32'(log_ld[0]),   32'b10);
            check("t35_idx",  32'(log_idx[0]),  32'd35);
            check("t35_data", 32'(log_data[0]), 32'h5A);
        end
        check("t35_done_lat", 32'(done_cyc - apply_cyc), 32'(PASS_LAT));
        check("t35_set_lat",  32'(set_cyc - apply_cyc),  32'(PASS_LAT - 1));

        // Invalid addresses only: nothing loaded, set/done still issued
        write(0, 10, 8'h11);
        write(0, 25, 8'h22);
        clear_log();
        apply = 1'b1;
        run_until_done("t36", 200);
        check("t36_pulses", 32'(log_idx.size()), 32'd0);
        check("t36_set",    32'(set_cnt),  32'd1);
        check("t36_done",   32'(done_cnt), 32'd1);

        // Full table, apply_all twice, then apply
        do_reset(2);
        for (int k = 0; k < NI; k++) begin
            if (tb_valid(k % 32)) begin
                write(k / 32, k % 32, int'($urandom_range(255)));
                exp_q.push_back(k);
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            clear_log();
            apply_all = 1'b1;
            run_until_done($sformatf("t37_all%0d", pass), 200);
            check($sformatf("t37_all%0d_pulses", pass), 32'(log_idx.size()), 32'd38);
            for (int i = 0; i < log_idx.size() && i < exp_q.size(); i++) begin
                check($sformatf("t37_order_%0d", i), 32'(log_idx[i]), 32'(exp_q[i]));
            end
        end
        clear_log();
        apply = 1'b1;
        run_until_done("t37_apply", 200);
        check("t37_apply_pulses", 32'(log_idx.size()), 32'd0);

        // Writes behind and ahead of the scan pointer
        clear_log();
        apply = 1'b1;
        tick();                      // scanning index 0
        repeat (9) tick();           // scanning index 9
        write(0, 2, 8'hC3);          // index 2 already scanned
        write(1, 20, 8'h3C);         // index 52 not yet scanned
        run_until_done("t38a", 200);
        check("t38a_pulses", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() > 0) check("t38a_idx", 32'(log_idx[0]), 32'd52);
        clear_log();
        apply = 1'b1;
        run_until_done("t38b", 200);
        check("t38b_pulses", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() > 0) begin
            check("t38b_idx",  32'(log_idx[0]),  32'd2);
            check("t38b_data", 32'(log_data[0]), 32'hC3);
        end

        // Same-cycle write collision and a request held during the pass
        write(0, 4, 8'hA1);
        clear_log();
        apply = 1'b1;
        tick();                      // scanning index 0
        repeat (4) tick();           // scanning index 4
        write(0, 4, 8'hB2);          // collides with its own scan
        repeat (20) tick();
        apply = 1'b1;                // held until the pass finishes
        run_until_done("t39a", 200);
        d1 = done_cyc;
        check("t39a_pulses", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() > 0) check("t39a_data", 32'(log_data[0]), 32'hA1);
        clear_log();
        tick();
        check("t39_restart_busy", 32'(busy), 32'd1);
        run_until_done("t39b", 200);
        check("t39b_lat", 32'(done_cyc - d1), 32'(PASS_LAT));
        check("t39b_pulses", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() > 0) begin
            check("t39b_idx",  32'(log_idx[0]),  32'd4);
            check("t39b_data", 32'(log_data[0]), 32'hB2);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            wr_en     = ($urandom_range(2) == 0);
            wr_addr   = IW'($urandom);
            wr_data   = 8'($urandom);
            apply     = ($urandom_range(39) == 0);
            apply_all = ($urandom_range(79) == 0);
            tick();
        end

        // Reset in the middle of a pass
        do_reset(2);
        write(0, 5, 8'h55);
        write(1, 17, 8'h77);
        clear_log();
        apply = 1'b1;
        tick();                      // scanning index 0
        repeat (20) tick();          // scanning index 20
        rst = 1'b1;
        tick();
        check("t40_ld",   32'(ld_delay), 32'd0);
        check("t40_addr", 32'(dly_addr), 32'd0);
        check("t40_data", 32'(dly_data), 32'd0);
        check("t40_set",  32'(set),      32'd0);
        check("t40_busy", 32'(busy),     32'd0);
        check("t40_done", 32'(done),     32'd0);
        set_cnt = 0; done_cnt = 0;
        repeat (100) tick();
        check("t40_no_set",  32'(set_cnt),  32'd0);
        check("t40_no_done", 32'(done_cnt), 32'd0);
        clear_log();
        apply = 1'b1;
        run_until_done("t40b", 200);
        check("t40b_pulses", 32'(log_idx.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_load_sequencer.md
DELAY_LOAD_SEQUENCER -- requirements
Module: delay_load_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2: number of byte lanes driven (1..4).
REQ-002 SHALL have parameter SET_GAP, default 2: idle cycles between the last load cycle and the set pulse (1..7).
REQ-003 SHALL have port clk_div, input, 1: sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1: host write strobe into the delay table.
REQ-006 SHALL have port wr_addr, input, log2(NUM_LANES)+5: {lane, 5-bit delay address}.
REQ-007 SHALL have port wr_data, input, 8: delay value; 3 LSBs are the fine delay.
REQ-008 SHALL have port apply, input, 1: one-cycle request to send dirty entries to the lanes.
REQ-009 SHALL have port apply_all, input, 1: one-cycle request to send all valid entries to the lanes.
REQ-010 SHALL have port dly_data, output, 8: delay value shared by all lanes.
REQ-011 SHALL have port dly_addr, output, 5: delay address shared by all lanes.
REQ-012 SHALL have port ld_delay, output, NUM_LANES: per-lane load strobe.
REQ-013 SHALL have port set, output, 1: broadcast strobe applying all loaded delays.
REQ-014 SHALL have port busy, output, 1: high from acceptance of a request until after the set pulse.
REQ-015 SHALL have port done, output, 1: one-cycle pulse in the cycle after set.

Function
REQ-016 Valid delay addresses SHALL be 0..9 (output delays: DQ0-7, DQS, DM) and 16..24 (input delays: DQ0-7, DQS); all other addresses are invalid.
REQ-017 Table SHALL hold NUM_LANES*32 entries of 8 bits, indexed {lane, addr}, each with a dirty bit.
REQ-018 wr_en to a valid address SHALL write the data and set the dirty bit; writes to invalid addresses or lanes >= NUM_LANES SHALL be ignored.
REQ-019 States SHALL be IDLE, SCAN, GAP, SET and DONE.
REQ-020 IDLE: apply or apply_all SHALL move to SCAN with index 0 and busy=1 on the next cycle; apply_all SHALL take priority when both are high.
REQ-021 SCAN: index SHALL advance by 1 each cycle from 0 to NUM_LANES*32-1; after the last index the state SHALL be GAP.
REQ-022 For a scanned index that is valid and dirty, or valid in apply_all mode, the block SHALL drive dly_addr/dly_data and a one-hot ld_delay[lane] for exactly one cycle; otherwise ld_delay SHALL be 0.
REQ-023 Output latency SHALL be 1 cycle: ld_delay for index k is asserted on the cycle after index k is scanned. dly_addr and dly_data SHALL hold their last values when ld_delay is 0.
REQ-024 The dirty bit of an emitted entry SHALL be cleared, unless wr_en hits the same index in the same cycle, in which case the old data is emitted and the bit stays set.
REQ-025 A write to an index not yet scanned SHALL be emitted in the current pass; a write to an index already scanned SHALL stay dirty for the next apply.
REQ-026 GAP SHALL last SET_GAP cycles. SET SHALL assert set for 1 cycle. DONE SHALL assert done for 1 cycle with busy=0, then return to IDLE.
REQ-027 Total latency from apply to done SHALL be NUM_LANES*32 + SET_GAP + 2 cycles, independent of dirty count.
REQ-028 A pass with no entries emitted SHALL still issue set and done.
REQ-029 apply or apply_all received while busy SHALL be latched as one pending request (apply_all sticky); it SHALL start in the cycle after DONE.

Reset
REQ-030 rst SHALL force IDLE and clear index, pending requests and all dirty bits; table data is not reset.
REQ-031 During and after reset, ld_delay, set, busy and done SHALL be 0, and dly_addr and dly_data SHALL be 0.
REQ-032 rst mid-pass SHALL abort the pass with no set pulse and no done pulse.

Structure
REQ-033 A shared package SHALL hold the address-map constants (ODLY_BASE=0, ODLY_CNT=10, IDLY_BASE=16, IDLY_CNT=9), the state encoding, and the index-width function.
REQ-034 Table storage SHALL be one sub-module, dly_table_ram, with 1 write port and 1 read port, distributed RAM, combinational read. Dirty bits SHALL be a flop vector in the parent.

Verification
REQ-035 With NUM_LANES=2: write lane 1 addr 3 = 0x5A, then apply -> exactly one ld_delay=2'b10 with dly_addr=3 and dly_data=0x5A; set 1 cycle after the gap; done 68 cycles after apply.
REQ-036 Write lane 0 addr 10 and addr 25 only, then apply -> no ld_delay pulses; set and done still occur.
REQ-037 After reset, write all 38 valid entries, then apply_all -> 38 ld_delay pulses in ascending index order; a second apply_all -> 38 pulses again; a following apply -> 0 pulses.
REQ-038 During a pass, write lane 0 addr 2 after its scan and lane 1 addr 20 before its scan -> only addr 20 is loaded; the next apply loads addr 2.
REQ-039 Write an index in the same cycle it is scanned -> the old value is emitted and the next apply emits the new value. Assert apply mid-pass -> a second pass starts the cycle after DONE.
REQ-040 Assert rst at index 20 -> all outputs 0 next cycle, no set or done; a following apply emits nothing that was written before the reset.
